// File: rtl/ex_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM pipeline register slice.
//   DATA_W_DEF / REG_W_DEF : default datapath and register-index widths.
//   mem_ctrl_t             : control bundle carried from EX into MEM.
//   CTRL_BUBBLE            : all-zero control bundle used for bubbles.
// ----------------------------------------------------------------------------
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic bge;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage : ex_mem_stage_pkg

// File: rtl/ex_mem_stage_branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
// Purely combinational branch decision. Kept separate so an earlier-stage
// resolver can reuse the same equation.
// Ports:
//   valid  in  : slot holds a real instruction
//   branch in  : beq
//   bge    in  : bge
//   zero   in  : ALU Zero flag
//   pos    in  : ALU Pos flag
//   pc_src out : branch taken
// ----------------------------------------------------------------------------
module branch_resolve (
    input  logic valid,
    input  logic branch,
    input  logic bge,
    input  logic zero,
    input  logic pos,
    output logic pc_src
);

    always_comb begin
        pc_src = valid & ((branch & zero) | (bge & pos));
    end

endmodule : branch_resolve

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register with branch resolution.
//
// Configuration macro: EX_MEM_BGE_EN
//   defined   : bge is registered and can take a branch (bge_q & pos_q).
//   undefined : ex_bge / ex_pos are ignored; only beq can take a branch.
//
// Ports:
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   ex_*                   : instruction fields arriving from EX
//   stall                  : downstream busy, hold every register
//   flush                  : kill the instruction currently in EX
//   mem_*                  : registered copies of the ex_* fields
//   pc_src                 : taken branch resolved from registered state
//   branch_flush           : squash IF/ID and ID/EX (same as pc_src)
//
// Flow control: there is no valid/ready pair here. stall=1 freezes the whole
// slice (including while flush=1); with stall=0 the slice loads every cycle,
// either the EX instruction or a bubble when it must be killed. Update
// priority per edge: reset > stall > kill > load.
// ----------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic              ex_pos,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic              ex_branch,
    input  logic              ex_bge,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic [DATA_W-1:0] mem_branch_target,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              pc_src,
    output logic              branch_flush
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              valid_q,        valid_d;
    logic [DATA_W-1:0] result_q,       result_d;
    logic [DATA_W-1:0] store_data_q,   store_data_d;
    logic [REG_W-1:0]  rd_q,           rd_d;
    logic [DATA_W-1:0] target_q,       target_d;
    logic              mem_read_q,     mem_read_d;
    logic              mem_write_q,    mem_write_d;
    logic              reg_write_q,    reg_write_d;
    logic              mem_to_reg_q,   mem_to_reg_d;
    logic              branch_q,       branch_d;
    logic              zero_q,         zero_d;
`ifdef EX_MEM_BGE_EN
    logic              bge_q,          bge_d;
    logic              pos_q,          pos_d;
`endif

    mem_ctrl_t ex_ctrl;   // incoming control, gated by ex_valid
    logic      kill;
    logic      bge_res;
    logic      pos_res;

    // Control bits of a non-instruction must never reach MEM.
    always_comb begin
        ex_ctrl            = CTRL_BUBBLE;
        ex_ctrl.mem_read   = ex_mem_read;
        ex_ctrl.mem_write  = ex_mem_write;
        ex_ctrl.reg_write  = ex_reg_write;
        ex_ctrl.mem_to_reg = ex_mem_to_reg;
        ex_ctrl.branch     = ex_branch;
        ex_ctrl.bge        = ex_bge;
        if (!ex_valid) begin
            ex_ctrl = CTRL_BUBBLE;
        end
    end

    // A taken branch in MEM squashes the younger instruction sitting in EX.
    assign kill = flush | pc_src;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        target_d     = target_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        zero_d       = zero_q;
`ifdef EX_MEM_BGE_EN
        bge_d        = bge_q;
        pos_d        = pos_q;
`endif
        if (!stall) begin
            if (kill) begin
                valid_d      = 1'b0;
                result_d     = '0;
                store_data_d = '0;
                rd_d         = '0;
                target_d     = '0;
                mem_read_d   = CTRL_BUBBLE.mem_read;
                mem_write_d  = CTRL_BUBBLE.mem_write;
                reg_write_d  = CTRL_BUBBLE.reg_write;
                mem_to_reg_d = CTRL_BUBBLE.mem_to_reg;
                branch_d     = CTRL_BUBBLE.branch;
                zero_d       = 1'b0;
`ifdef EX_MEM_BGE_EN
                bge_d        = CTRL_BUBBLE.bge;
                pos_d        = 1'b0;
`endif
            end else begin
                valid_d      = ex_valid;
                result_d     = ex_result;
                store_data_d = ex_store_data;
                rd_d         = ex_rd;
                target_d     = ex_branch_target;
                mem_read_d   = ex_ctrl.mem_read;
                mem_write_d  = ex_ctrl.mem_write;
                reg_write_d  = ex_ctrl.reg_write;
                mem_to_reg_d = ex_ctrl.mem_to_reg;
                branch_d     = ex_ctrl.branch;
                zero_d       = ex_zero;
`ifdef EX_MEM_BGE_EN
                bge_d        = ex_ctrl.bge;
                pos_d        = ex_pos;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            target_q     <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            zero_q       <= 1'b0;
`ifdef EX_MEM_BGE_EN
            bge_q        <= 1'b0;
            pos_q        <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            target_q     <= target_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            zero_q       <= zero_d;
`ifdef EX_MEM_BGE_EN
            bge_q        <= bge_d;
            pos_q        <= pos_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
`ifdef EX_MEM_BGE_EN
    assign bge_res = bge_q;
    assign pos_res = pos_q;
`else
    // bge support compiled out: the resolver sees a permanently-off bge.
    assign bge_res = 1'b0;
    assign pos_res = 1'b0;
    logic unused_bge_inputs;
    assign unused_bge_inputs = ex_pos ^ ex_ctrl.bge;
`endif

    branch_resolve u_branch_resolve (
        .valid  (valid_q),
        .branch (branch_q),
        .bge    (bge_res),
        .zero   (zero_q),
        .pos    (pos_res),
        .pc_src (pc_src)
    );

    assign branch_flush = pc_src;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_valid         = valid_q;
    assign mem_result        = result_q;
    assign mem_store_data    = store_data_q;
    assign mem_rd            = rd_q;
    assign mem_branch_target = target_q;
    assign mem_mem_read      = mem_read_q;
    assign mem_mem_write     = mem_write_q;
    assign mem_reg_write     = reg_write_q;
    assign mem_mem_to_reg    = mem_to_reg_q;

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic              ex_pos;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_branch_target;
    logic              ex_branch;
    logic              ex_bge;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_W-1:0]  mem_rd;
    logic [DATA_W-1:0] mem_branch_target;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic              pc_src;
    logic              branch_flush;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_result         (ex_result),
        .ex_zero           (ex_zero),
        .ex_pos            (ex_pos),
        .ex_store_data     (ex_store_data),
        .ex_rd             (ex_rd),
        .ex_branch_target  (ex_branch_target),
        .ex_branch         (ex_branch),
        .ex_bge            (ex_bge),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_to_reg     (ex_mem_to_reg),
        .stall             (stall),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .mem_result        (mem_result),
        .mem_store_data    (mem_store_data),
        .mem_rd            (mem_rd),
        .mem_branch_target (mem_branch_target),
        .mem_mem_read      (mem_mem_read),
        .mem_mem_write     (mem_mem_write),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_to_reg    (mem_mem_to_reg),
        .pc_src            (pc_src),
        .branch_flush      (branch_flush)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_idle();
        ex_valid         = 1'b0;
        ex_result        = '0;
        ex_zero          = 1'b0;
        ex_pos           = 1'b0;
        ex_store_data    = '0;
        ex_rd            = '0;
        ex_branch_target = '0;
        ex_branch        = 1'b0;
        ex_bge           = 1'b0;
        ex_mem_read      = 1'b0;
        ex_mem_write     = 1'b0;
        ex_reg_write     = 1'b0;
        ex_mem_to_reg    = 1'b0;
        stall            = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic drive_beq(input logic [63:0] target);
        drive_idle();
        ex_valid         = 1'b1;
        ex_branch        = 1'b1;
        ex_zero          = 1'b1;
        ex_result        = 64'h0;
        ex_branch_target = target;
    endtask

    // Advance one clock; land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_bge_taken;

    initial begin
`ifdef EX_MEM_BGE_EN
        exp_bge_taken = 1'b1;
`else
        exp_bge_taken = 1'b0;
`endif
        drive_idle();
        reset = 1'b1;

        // Reset state
        #2;
        check_eq("rst_valid",  mem_valid,  0);
        check_eq("rst_pc_src", pc_src,     0);
        check_eq("rst_bflush", branch_flush, 0);
        check_eq("rst_result", mem_result, 0);
        step();
        reset = 1'b0;

        // Plain load
        drive_idle();
        ex_valid      = 1'b1;
        ex_result     = 64'h10;
        ex_store_data = 64'hABCD;
        ex_rd         = 5'd3;
        ex_reg_write  = 1'b1;
        step();
        check_eq("ld_valid",  mem_valid,      1);
        check_eq("ld_result", mem_result,     64'h10);
        check_eq("ld_store",  mem_store_data, 64'hABCD);
        check_eq("ld_rd",     mem_rd,         3);
        check_eq("ld_regw",   mem_reg_write,  1);
        check_eq("ld_pc_src", pc_src,         0);

        // beq taken, then younger instruction squashed
        drive_beq(64'h200);
        step();
        check_eq("beq_pc_src", pc_src,            1);
        check_eq("beq_bflush", branch_flush,      1);
        check_eq("beq_target", mem_branch_target, 64'h200);
        drive_idle();
        ex_valid     = 1'b1;
        ex_reg_write = 1'b1;
        ex_result    = 64'h77;
        step();
        check_eq("sq_valid",  mem_valid,     0);
        check_eq("sq_regw",   mem_reg_write, 0);
        check_eq("sq_result", mem_result,    0);
        check_eq("sq_pc_src", pc_src,        0);

        // Stall hold while a taken branch sits in MEM, flush asserted
        drive_beq(64'h300);
        step();
        check_eq("st_pre_pc_src", pc_src, 1);
        drive_idle();
        ex_valid     = 1'b1;
        ex_result    = 64'h55;
        ex_reg_write = 1'b1;
        stall        = 1'b1;
        flush        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("st_pc_src", pc_src,            1);
            check_eq("st_valid",  mem_valid,         1);
            check_eq("st_target", mem_branch_target, 64'h300);
            check_eq("st_regw",   mem_reg_write,     0);
        end
        stall = 1'b0;
        flush = 1'b0;
        step();
        check_eq("st_rel_valid",  mem_valid,  0);
        check_eq("st_rel_result", mem_result, 0);
        check_eq("st_rel_pc_src", pc_src,     0);

        // bge: taken only when support is compiled in
        drive_idle();
        ex_valid         = 1'b1;
        ex_bge           = 1'b1;
        ex_pos           = 1'b1;
        ex_zero          = 1'b0;
        ex_branch_target = 64'h400;
        step();
        check_eq("bge_pc_src", pc_src,    exp_bge_taken);
        check_eq("bge_valid",  mem_valid, 1);
        drive_idle();
        step();
        check_eq("bge_after_pc_src", pc_src, 0);

        // External flush
        drive_idle();
        ex_valid     = 1'b1;
        ex_mem_write = 1'b1;
        flush        = 1'b1;
        step();
        check_eq("fl_valid", mem_valid,     0);
        check_eq("fl_memw",  mem_mem_write, 0);

        // ex_valid=0 forces control bits off
        drive_idle();
        ex_mem_read   = 1'b1;
        ex_reg_write  = 1'b1;
        ex_mem_to_reg = 1'b1;
        ex_branch     = 1'b1;
        ex_zero       = 1'b1;
        step();
        check_eq("inv_valid", mem_valid,      0);
        check_eq("inv_memr",  mem_mem_read,   0);
        check_eq("inv_regw",  mem_reg_write,  0);
        check_eq("inv_m2r",   mem_mem_to_reg, 0);
        check_eq("inv_pcsrc", pc_src,         0);

        // Load with mem_read / mem_to_reg
        drive_idle();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_to_reg = 1'b1;
        ex_rd         = 5'd31;
        step();
        check_eq("lw_memr", mem_mem_read,   1);
        check_eq("lw_m2r",  mem_mem_to_reg, 1);
        check_eq("lw_rd",   mem_rd,         31);

        // Async reset between edges while a branch is held in a stall
        drive_beq(64'h500);
        step();
        check_eq("ar_pre_pc_src", pc_src, 1);
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_pc_src", pc_src,            0);
        check_eq("ar_bflush", branch_flush,      0);
        check_eq("ar_valid",  mem_valid,         0);
        check_eq("ar_target", mem_branch_target, 0);
        check_eq("ar_rd",     mem_rd,            0);
        #2;
        reset = 1'b0;
        // First edge after release: stall=1 holds the reset values
        step();
        check_eq("ar_hold_valid", mem_valid, 0);
        stall = 1'b0;
        step();
        check_eq("ar_load_valid",  mem_valid,         1);
        check_eq("ar_load_pc_src", pc_src,            1);
        check_eq("ar_load_target", mem_branch_target, 64'h500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_mem_stage
